uart_cmd_decode: RTL
====================

Name: uart_cmd_decode

Overview:
Byte-stream command parser placed directly downstream of the UART receiver. It consumes the receiver's 8-bit byte / single-cycle valid pulse and recognises framed commands of the form HEAD, CMD, LEN, [payload]. Write frames stream their payload into the SDRAM write FIFO and then pulse a write trigger. Read frames pulse a read trigger with the requested burst length. An inter-byte timeout aborts partial frames.

Parameters:
HEAD, 8'h55, frame header byte
CMD_WR, 8'hAA, write command code
CMD_RD, 8'hA5, read command code
MAX_LEN, 64, largest legal LEN value (1..255)
TIMEOUT_MAX, 13019, clock cycles allowed between bytes inside a frame (3 byte times at 50 MHz/115200)

Ports:
sclk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid only when rx_flag=1
rx_flag  in  1  one-cycle byte-valid pulse from the UART receiver
wfifo_wr_en  out  1  one-cycle write strobe into the SDRAM write FIFO
wfifo_wr_data  out  8  payload byte, valid with wfifo_wr_en
wr_trig  out  1  one-cycle pulse: complete write frame received
rd_trig  out  1  one-cycle pulse: complete read frame received
burst_len  out  8  LEN of the last accepted frame, held until the next accepted frame
frame_err  out  1  one-cycle pulse: frame aborted

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is sclk. All outputs reset to 0. State resets to IDLE, and cnt_to and cnt_data reset to 0.
- All outputs are registered. Each response appears on the cycle after the rx_flag cycle that caused it, i.e. 1-cycle latency.
- FSM states: IDLE, CMD, LEN, DATA. Transitions are evaluated only on rx_flag=1, except for the timeout.
- IDLE: if rx_data==HEAD, go to CMD. Any other byte is ignored with no error.
- CMD:
  - CMD_WR: latch is_wr=1, go to LEN.
  - CMD_RD: latch is_wr=0, go to LEN.
  - rx_data==HEAD: stay in CMD (re-sync on a repeated header), no error.
  - Anything else: frame_err, go to IDLE.
- LEN:
  - LEN==0 or LEN>MAX_LEN: frame_err, go to IDLE.
  - Read frame: burst_len<=LEN, rd_trig, go to IDLE.
  - Write frame: burst_len<=LEN, cnt_data<=0, go to DATA.
- DATA:
  - Each byte produces wfifo_wr_en with wfifo_wr_data=rx_data, and cnt_data increments.
  - On the byte where cnt_data==burst_len-1, wr_trig fires in the same cycle as the final wfifo_wr_en, cnt_data clears, and the FSM goes to IDLE.
  - Payload bytes equal to HEAD are plain data; there is no re-sync inside DATA.
- Timeout:
  - cnt_to (14-bit) clears on every rx_flag and whenever the state is IDLE.
  - Otherwise cnt_to increments each cycle.
  - At cnt_to==TIMEOUT_MAX: frame_err, go to IDLE, clear cnt_data. Bytes already pushed to the FIFO are not retracted and wr_trig is not issued.
- Simultaneous events: if rx_flag arrives in the same cycle cnt_to reaches TIMEOUT_MAX, the byte wins, the timer clears, and no error is raised.
- burst_len is updated only on an accepted LEN; it is unchanged on error.
- wr_trig and rd_trig are never asserted in the same cycle. Each frame produces at most one trigger or one frame_err, never both.
- Reset asserted mid-frame returns to IDLE immediately with all outputs at 0. The next frame must start with HEAD.

Decomposition:
- The shared package holds:
  - the HEAD/CMD_WR/CMD_RD byte constants;
  - the state encoding (IDLE=2'd0, CMD=2'd1, LEN=2'd2, DATA=2'd3);
  - the default TIMEOUT_MAX.
- A single module is sufficient. The timeout counter may optionally be split out as uart_gap_timer (en, clr, expire pulse), and is reusable by other UART-side blocks.

Test Plan:
- Read frame 55 A5 10 at 115200 baud -> one rd_trig pulse, burst_len=8'h10, no wfifo_wr_en, no frame_err.
- Write frame 55 AA 04 11 22 55 44 -> four wfifo_wr_en pulses with data 11,22,55,44; wr_trig coincident with the strobe for byte 44; burst_len=4.
- Bad frames:
  - 55 3C -> frame_err one cycle after the 3C flag, return to IDLE.
  - 55 AA 00 -> frame_err.
  - 55 AA 41 with MAX_LEN=64 -> frame_err; burst_len keeps its prior value.
- Re-sync and noise: 55 55 A5 02 -> rd_trig, burst_len=2. Leading junk bytes 00 FF before 55 are ignored silently.
- Timeout: 55 AA 03 11, then idle for > TIMEOUT_MAX cycles -> exactly one wfifo_wr_en, frame_err at cycle TIMEOUT_MAX+1 after the 11 flag, no wr_trig. A following complete frame decodes correctly.
- Reset: assert rst_n low during the DATA phase of a write frame -> all outputs 0 immediately. After release, feed 55 A5 01 -> rd_trig, burst_len=1.

Source files
------------

// File: rtl/uart_cmd_decode_pkg.sv
// rtl/uart_cmd_decode_pkg.sv - shared constants and state encoding for the UART command decoder
package uart_cmd_decode_pkg;

  localparam logic [7:0] HEAD   = 8'h55;
  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hA5;

  localparam int MAX_LEN_DEF     = 64;
  localparam int TIMEOUT_MAX_DEF = 13019;
  localparam int TO_W            = 14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_LEN  = 2'd2,
    ST_DATA = 2'd3
  } state_t;

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte gap counter with a single-cycle expire indication
module uart_gap_timer #(
  parameter int W   = 14,
  parameter int MAX = 13019
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A clear in the same cycle wins, so an arriving byte suppresses expiry
  assign expire = en && !clr && (cnt == MAX_C);

endmodule

// File: rtl/uart_cmd_decode.sv
// rtl/uart_cmd_decode.sv - framed command parser (HEAD, CMD, LEN, payload) behind the UART receiver
module uart_cmd_decode
  import uart_cmd_decode_pkg::*;
#(
  parameter int MAX_LEN     = MAX_LEN_DEF,
  parameter int TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_flag,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_wr_data,
  output logic       wr_trig,
  output logic       rd_trig,
  output logic [7:0] burst_len,
  output logic       frame_err
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state;
  logic       is_wr;
  logic [7:0] cnt_data;
  logic       to_expire;

  uart_gap_timer #(
    .W   (TO_W),
    .MAX (TIMEOUT_MAX)
  ) u_gap_timer (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .en     (state != ST_IDLE),
    .clr    (rx_flag || (state == ST_IDLE)),
    .expire (to_expire)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      is_wr         <= 1'b0;
      cnt_data      <= '0;
      wfifo_wr_en   <= 1'b0;
      wfifo_wr_data <= '0;
      wr_trig       <= 1'b0;
      rd_trig       <= 1'b0;
      burst_len     <= '0;
      frame_err     <= 1'b0;
    end else begin
      wfifo_wr_en <= 1'b0;
      wr_trig     <= 1'b0;
      rd_trig     <= 1'b0;
      frame_err   <= 1'b0;
      if (rx_flag) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == HEAD) state <= ST_CMD;
          end
          ST_CMD: begin
            if (rx_data == CMD_WR) begin
              is_wr <= 1'b1;
              state <= ST_LEN;
            end else if (rx_data == CMD_RD) begin
              is_wr <= 1'b0;
              state <= ST_LEN;
            end else if (rx_data != HEAD) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          ST_LEN: begin
            if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              burst_len <= rx_data;
              if (is_wr) begin
                cnt_data <= '0;
                state    <= ST_DATA;
              end else begin
                rd_trig <= 1'b1;
                state   <= ST_IDLE;
              end
            end
          end
          ST_DATA: begin
            // HEAD bytes are payload here; only the length ends the frame
            wfifo_wr_en   <= 1'b1;
            wfifo_wr_data <= rx_data;
            if (cnt_data == burst_len - 8'd1) begin
              wr_trig  <= 1'b1;
              cnt_data <= '0;
              state    <= ST_IDLE;
            end else begin
              cnt_data <= cnt_data + 8'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (to_expire) begin
        frame_err <= 1'b1;
        cnt_data  <= '0;
        state     <= ST_IDLE;
      end
    end
  end

endmodule
